// File: rtl/sp_write_arbiter.sv
// Scratchpad request arbiter: two source FIFOs, round-robin grant, one registered output, outstanding tracking.
// Optional performance counters are enabled by defining SP_ARB_PERF_EN.
module sp_write_arbiter #(
  parameter int REQ_W      = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             mls_valid,
  input  logic [REQ_W-1:0] mls_data,
  output logic             mls_ready,
  input  logic             gemm_valid,
  input  logic [REQ_W-1:0] gemm_data,
  output logic             gemm_ready,
  output logic             sp_valid,
  output logic [REQ_W-1:0] sp_data,
  output logic             sp_src,
  input  logic             sp_ready,
  input  logic             sp_done,
  input  logic             sp_done_src,
  output logic             mls_done,
  output logic             gemm_done,
  output logic             err_underflow
`ifdef SP_ARB_PERF_EN
  ,
  output logic [31:0]      perf_mls_grants,
  output logic [31:0]      perf_gemm_grants,
  output logic [31:0]      perf_stall_cyc,
  output logic [31:0]      perf_starve_cyc
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  logic [1:0]       in_vld;
  logic [REQ_W-1:0] in_data [2];

  assign in_vld     = {gemm_valid, mls_valid};
  assign in_data[0] = mls_data;
  assign in_data[1] = gemm_data;

  logic [REQ_W-1:0] mem_q  [2][FIFO_DEPTH];
  logic [PW-1:0]    wptr_q [2];
  logic [PW-1:0]    wptr_d [2];
  logic [PW-1:0]    rptr_q [2];
  logic [PW-1:0]    rptr_d [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  logic [OW-1:0]    ocnt_q [2];
  logic [OW-1:0]    ocnt_d [2];

  logic [1:0]       full, push, pop, elig, done_hit;
  logic             load, gnt;
  logic             sp_valid_q, sp_valid_d;
  logic             sp_src_q, sp_src_d;
  logic             rr_q, rr_d;
  logic [REQ_W-1:0] sp_data_q, sp_data_d;
  logic             mls_done_q, mls_done_d;
  logic             gemm_done_q, gemm_done_d;
  logic             err_q, err_d;

  always_comb begin
    full        = '0;
    push        = '0;
    pop         = '0;
    elig        = '0;
    done_hit    = '0;
    sp_valid_d  = sp_valid_q;
    sp_data_d   = sp_data_q;
    sp_src_d    = sp_src_q;
    rr_d        = rr_q;
    for (int s = 0; s < 2; s++) begin
      full[s]     = (cnt_q[s] == CW'(FIFO_DEPTH));
      push[s]     = in_vld[s] && !full[s];
      elig[s]     = (cnt_q[s] != '0) && (ocnt_q[s] < OW'(MAX_OUT));
      done_hit[s] = sp_done && (int'(sp_done_src) == s) && (ocnt_q[s] != '0);
    end

    // Output register advances only when empty or being consumed; ties go to the source not granted last.
    load = (!sp_valid_q || sp_ready) && (elig != 2'b00);
    gnt  = elig[1] && (!elig[0] || !rr_q);
    if (load) begin
      pop[gnt]   = 1'b1;
      sp_valid_d = 1'b1;
      sp_data_d  = mem_q[gnt][rptr_q[gnt]];
      sp_src_d   = gnt;
      rr_d       = gnt;
    end else if (sp_ready) begin
      sp_valid_d = 1'b0;
    end

    for (int s = 0; s < 2; s++) begin
      wptr_d[s] = push[s] ? wptr_q[s] + PW'(1) : wptr_q[s];
      rptr_d[s] = pop[s]  ? rptr_q[s] + PW'(1) : rptr_q[s];
      case ({push[s], pop[s]})
        2'b10:   cnt_d[s] = cnt_q[s] + CW'(1);
        2'b01:   cnt_d[s] = cnt_q[s] - CW'(1);
        default: cnt_d[s] = cnt_q[s];
      endcase
      case ({pop[s], done_hit[s]})
        2'b10:   ocnt_d[s] = ocnt_q[s] + OW'(1);
        2'b01:   ocnt_d[s] = ocnt_q[s] - OW'(1);
        default: ocnt_d[s] = ocnt_q[s];
      endcase
    end

    mls_done_d  = done_hit[0];
    gemm_done_d = done_hit[1];
    err_d       = err_q || (sp_done && (ocnt_q[sp_done_src] == '0));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
        ocnt_q[s] <= '0;
      end
      sp_valid_q  <= 1'b0;
      sp_data_q   <= '0;
      sp_src_q    <= 1'b0;
      rr_q        <= 1'b1;
      mls_done_q  <= 1'b0;
      gemm_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
        cnt_q[s]  <= cnt_d[s];
        ocnt_q[s] <= ocnt_d[s];
      end
      sp_valid_q  <= sp_valid_d;
      sp_data_q   <= sp_data_d;
      sp_src_q    <= sp_src_d;
      rr_q        <= rr_d;
      mls_done_q  <= mls_done_d;
      gemm_done_q <= gemm_done_d;
      err_q       <= err_d;
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][wptr_q[s]] <= in_data[s];
    end
  end

  assign mls_ready     = !full[0];
  assign gemm_ready    = !full[1];
  assign sp_valid      = sp_valid_q;
  assign sp_data       = sp_data_q;
  assign sp_src        = sp_src_q;
  assign mls_done      = mls_done_q;
  assign gemm_done     = gemm_done_q;
  assign err_underflow = err_q;

`ifdef SP_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  logic        starve;
  logic [31:0] pm_q, pg_q, pstall_q, pstarve_q;

  always_comb begin
    starve = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if ((cnt_q[s] != '0) && (ocnt_q[s] >= OW'(MAX_OUT))) starve = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pm_q      <= '0;
      pg_q      <= '0;
      pstall_q  <= '0;
      pstarve_q <= '0;
    end else begin
      pm_q      <= sat_inc(pm_q, pop[0]);
      pg_q      <= sat_inc(pg_q, pop[1]);
      pstall_q  <= sat_inc(pstall_q, sp_valid_q && !sp_ready);
      pstarve_q <= sat_inc(pstarve_q, starve);
    end
  end

  assign perf_mls_grants  = pm_q;
  assign perf_gemm_grants = pg_q;
  assign perf_stall_cyc   = pstall_q;
  assign perf_starve_cyc  = pstarve_q;
`endif

endmodule
